// File: rtl/entropy_pool.sv
`default_nettype none
// ============================================================================
// Module      : entropy_pool
// Description : Folds a WIDTH-bit entropy word into a (WIDTH-1)-bit rotating
//               pool every clock and emits pool bit 0 as a serial random bit.
//               The odd pool length makes successive words land on different
//               bit alignments, so every input bit eventually reaches e_bit.
// Revision    : 1.0 - initial release
// ============================================================================
module entropy_pool #(
  parameter int WIDTH = 16  // entropy word width, must be >= 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] e_word,
  output logic             e_bit
);

  localparam int c_POOL_W = WIDTH - 1;

  // Pool state and its combinational next value (kept as named nets so they
  // stay visible hierarchically).
  logic [c_POOL_W-1:0] e_pool;
  logic [c_POOL_W-1:0] e_pool_mod;

  logic [c_POOL_W-1:0] w_rot;
  logic [c_POOL_W-1:0] w_fold;

  // Rotate right by one so bit 0 wraps to the pool MSB.
  assign w_rot = {e_pool[0], e_pool[c_POOL_W-1:1]};

  // The word MSB has no pool slot of its own; fold it onto the pool MSB.
  assign w_fold = e_word[c_POOL_W-1:0] ^ {e_word[WIDTH-1], {(c_POOL_W-1){1'b0}}};

  // XOR mixing; an all-zero word leaves a pure rotation.
  assign e_pool_mod = w_rot ^ w_fold;

  // Pool register: cleared asynchronously, otherwise updated every edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_pool <= '0;
    end else begin
      e_pool <= e_pool_mod;
    end
  end

  // Serial output comes straight from the registered pool LSB.
  assign e_bit = e_pool[0];

endmodule
`default_nettype wire

// File: tb/tb_entropy_pool.sv
`default_nettype none
// ============================================================================
// Module      : tb_entropy_pool
// Description : Self-checking bench for entropy_pool (WIDTH = 16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_entropy_pool;

  localparam int W  = 16;
  localparam int PW = W - 1;

  logic          clk;
  logic          rst_n;
  logic [W-1:0]  e_word;
  logic          e_bit;

  int vectors;
  int miscompares;

  // Reference pool value, tracked as a plain integer.
  int unsigned m_pool;

  entropy_pool #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .e_word (e_word),
    .e_bit  (e_bit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rotate right by one position within a PW-bit ring, via arithmetic.
  function automatic int unsigned ring_rot(input int unsigned p);
    return (p / 2) + (p % 2) * (2 ** (PW - 1));
  endfunction

  // Word contribution: low PW bits, with the word MSB added onto the pool MSB.
  function automatic int unsigned fold_word(input int unsigned w);
    int unsigned lo;
    int unsigned hi;
    lo = w % (2 ** PW);
    hi = (w / (2 ** PW)) % 2;
    return lo ^ (hi * (2 ** (PW - 1)));
  endfunction

  function automatic int unsigned model_next(input int unsigned p, input int unsigned w);
    return ring_rot(p) ^ fold_word(w);
  endfunction

  // Present a word for exactly one rising edge and advance the model.
  task automatic apply(input logic [W-1:0] w);
    int unsigned exp_next;
    @(negedge clk);
    e_word = w;
    #1;
    exp_next = model_next(m_pool, int'(w));
    vectors++;
    if (int'(dut.e_pool_mod) !== int'(exp_next)) begin
      miscompares++;
      $display("FAIL next_state: got %h expected %h", dut.e_pool_mod, exp_next[PW-1:0]);
    end
    @(posedge clk);
    #1;
    m_pool = exp_next;
  endtask

  task automatic check_pool(input string name);
    vectors++;
    if ((int'(dut.e_pool) !== int'(m_pool)) || (e_bit !== m_pool[0])) begin
      miscompares++;
      $display("FAIL %s: pool %h e_bit %b expected pool %h e_bit %b",
               name, dut.e_pool, e_bit, m_pool[PW-1:0], m_pool[0]);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n  = 1'b0;
    e_word = W'($urandom);
    #1;
    m_pool = 0;
    repeat (2) begin
      @(negedge clk);
      e_word = W'($urandom);
    end
    rst_n  = 1'b1;
    e_word = '0;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    e_word = W'($urandom);
    #2;
    m_pool = 0;
    check_pool("reset_async");
    repeat (3) begin
      @(posedge clk);
      e_word = W'($urandom);
      #1;
      check_pool("reset_held");
    end
    @(negedge clk);
    rst_n  = 1'b1;
    e_word = '0;
  endtask

  task automatic test_single_word();
    logic [14:0] exp_seq;
    do_reset();
    apply(16'b0111110000111001);
    vectors++;
    if (dut.e_pool !== 15'h7C39 || e_bit !== 1'b1) begin
      miscompares++;
      $display("FAIL single_word_pool: pool %h e_bit %b expected 7c39 1", dut.e_pool, e_bit);
    end
    // Expected e_bit over the next 15 edges, first element in bit 14.
    exp_seq = 15'b001110000111111;
    for (int i = 0; i < 15; i++) begin
      apply('0);
      vectors++;
      if (e_bit !== exp_seq[14-i]) begin
        miscompares++;
        $display("FAIL single_word_bit%0d: got %b expected %b", i, e_bit, exp_seq[14-i]);
      end
    end
    vectors++;
    if (dut.e_pool !== 15'h7C39) begin
      miscompares++;
      $display("FAIL single_word_wrap: got %h expected 7c39", dut.e_pool);
    end
  endtask

  task automatic test_msb_fold();
    do_reset();
    apply(16'hAAAA);
    vectors++;
    if (dut.e_pool !== 15'h6AAA || e_bit !== 1'b0) begin
      miscompares++;
      $display("FAIL msb_fold: pool %h e_bit %b expected 6aaa 0", dut.e_pool, e_bit);
    end
  endtask

  task automatic test_accumulation();
    int unsigned ref_val;
    do_reset();
    apply(16'h7C39);
    repeat (11) apply('0);
    apply(16'hAAAA);
    ref_val = 32'h7C39;
    for (int i = 0; i < 12; i++) ref_val = ring_rot(ref_val);
    ref_val = ref_val ^ 32'h6AAA;
    vectors++;
    if (int'(dut.e_pool) !== int'(ref_val)) begin
      miscompares++;
      $display("FAIL accumulation: got %h expected %h", dut.e_pool, ref_val[PW-1:0]);
    end
    check_pool("accumulation_model");
  endtask

  task automatic test_idle_period();
    logic [PW-1:0] snap;
    logic [14:0]   bits;
    do_reset();
    apply(W'($urandom_range(1, 65535)) | 16'h0001);
    repeat (4) apply(W'($urandom));
    if (m_pool == 0) apply(16'h0001);
    snap = dut.e_pool;
    for (int i = 0; i < 15; i++) begin
      apply('0);
      bits[i] = e_bit;
    end
    vectors++;
    if (int'(dut.e_pool) !== int'(m_pool) || int'(snap) !== int'(m_pool)) begin
      miscompares++;
      $display("FAIL idle_period_pool: got %h expected %h", dut.e_pool, m_pool[PW-1:0]);
    end
    for (int i = 0; i < 15; i++) begin
      apply('0);
      vectors++;
      if (e_bit !== bits[i] || e_bit !== m_pool[0]) begin
        miscompares++;
        $display("FAIL idle_period_bit%0d: got %b expected %b", i, e_bit, m_pool[0]);
      end
    end
  endtask

  task automatic test_cancellation();
    logic [W-1:0] w;
    do_reset();
    w = W'($urandom_range(1, 65535));
    apply(w);
    repeat (14) apply('0);
    apply(w);
    vectors++;
    if (dut.e_pool !== '0 || e_bit !== 1'b0) begin
      miscompares++;
      $display("FAIL cancellation: pool %h e_bit %b expected 0 0", dut.e_pool, e_bit);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) apply('0);
      else apply(W'($urandom));
      check_pool("random");
    end
  endtask

  task automatic test_midstream_reset();
    repeat (5) apply(W'($urandom));
    @(negedge clk);
    #2;
    rst_n  = 1'b0;
    e_word = W'($urandom);
    #1;
    m_pool = 0;
    check_pool("midstream_reset");
    @(posedge clk);
    #1;
    check_pool("midstream_reset_held");
    @(negedge clk);
    rst_n  = 1'b1;
    e_word = '0;
    apply(16'h8001);
    check_pool("after_reset_release");
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    m_pool      = 0;
    test_reset();
    test_single_word();
    test_msb_fold();
    test_accumulation();
    test_idle_period();
    test_cancellation();
    test_random();
    test_midstream_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
